// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Two-master to one-slave Wishbone B4 pipelined arbiter. Master 0 is the L1
//   memory access unit and master 1 is a secondary master (debug or DMA). The
//   slave side is the system bus.
//
//   A master is granted for a whole bus cycle. The grant is taken one cycle
//   after its cyc rises and is held until the owner drops cyc. Simultaneous
//   requests are resolved round-robin (FIXED_PRIO=0) or always in favour of
//   master 0 (FIXED_PRIO=1). The master that is not granted sees stall=1,
//   ack=0, err=0 and dat=0.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width, byte select width is DATA_W/8
//   FIXED_PRIO  0 = round-robin, 1 = master 0 wins ties
//   TIMEOUT     watchdog limit in owned cycles (optional feature only)
//
// Ports
//   wb_clk_i, wb_rst_n_i                  clock, synchronous active-low reset
//   mN_cyc_i/stb_i/we_i/adr_i/dat_i/sel_i master N request (N = 0, 1)
//   mN_dat_o/ack_o/err_o/stall_o          master N response
//   wb_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o slave request
//   wb_dat_i/ack_i/err_i/stall_i          slave response
//
// Optional feature
//   WB_ARBITER_TIMEOUT_EN: when defined, a watchdog counts owned cycles with
//   neither ack nor err. On reaching TIMEOUT it pulses err to the owner for
//   one cycle with slave cyc forced low, releases the bus, and blocks that
//   master from being re-granted until it drops cyc.
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_W-1:0]     m0_adr_i,
  input  logic [DATA_W-1:0]     m0_dat_i,
  input  logic [DATA_W/8-1:0]   m0_sel_i,
  output logic [DATA_W-1:0]     m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_stall_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_W-1:0]     m1_adr_i,
  input  logic [DATA_W-1:0]     m1_dat_i,
  input  logic [DATA_W/8-1:0]   m1_sel_i,
  output logic [DATA_W-1:0]     m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_stall_o,

  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_W-1:0]     wb_adr_o,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic [DATA_W/8-1:0]   wb_sel_o,
  input  logic [DATA_W-1:0]     wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_stall_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t r_state;
  logic   r_lastGrant;
  logic   w_req0;
  logic   w_req1;
  logic   w_timeout;

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;
  logic             r_block0;
  logic             r_block1;

  // A master whose cycle was killed by the watchdog may not request again
  // until it has dropped cyc at least once.
  assign w_req0    = m0_cyc_i & ~r_block0;
  assign w_req1    = m1_cyc_i & ~r_block1;
  assign w_timeout = (r_state != ST_IDLE) && (r_count == CNT_W'(TIMEOUT));

  // Watchdog: counts owned cycles that bring neither ack nor err. It is held
  // at zero while idle so that every new ownership starts from zero. The
  // block flags remember which master was cut off until its cyc falls.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_count  <= '0;
      r_block0 <= 1'b0;
      r_block1 <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || wb_ack_i || wb_err_i) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end

      if (!m0_cyc_i) begin
        r_block0 <= 1'b0;
      end else if (w_timeout && r_state == ST_OWN0) begin
        r_block0 <= 1'b1;
      end

      if (!m1_cyc_i) begin
        r_block1 <= 1'b0;
      end else if (w_timeout && r_state == ST_OWN1) begin
        r_block1 <= 1'b1;
      end
    end
  end
`else
  assign w_req0    = m0_cyc_i;
  assign w_req1    = m1_cyc_i;
  assign w_timeout = 1'b0;
`endif

  // Grant state machine. r_lastGrant holds the master granted most recently
  // (reset to 1 so master 0 wins the first tie). Ownership is only released
  // through IDLE, which guarantees at least one cycle with slave cyc low
  // between two owners.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= ST_IDLE;
      r_lastGrant <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req0 && w_req1) begin
            if (FIXED_PRIO != 0 || r_lastGrant) begin
              r_state     <= ST_OWN0;
              r_lastGrant <= 1'b0;
            end else begin
              r_state     <= ST_OWN1;
              r_lastGrant <= 1'b1;
            end
          end else if (w_req0) begin
            r_state     <= ST_OWN0;
            r_lastGrant <= 1'b0;
          end else if (w_req1) begin
            r_state     <= ST_OWN1;
            r_lastGrant <= 1'b1;
          end
        end
        ST_OWN0: begin
          if (!m0_cyc_i || w_timeout) begin
            r_state <= ST_IDLE;
          end
        end
        ST_OWN1: begin
          if (!m1_cyc_i || w_timeout) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus steering from the registered grant. Outputs are also qualified by
  // the reset input so that the bus is quiet during every reset cycle,
  // including the first one before the state has been cleared. In the
  // watchdog cycle the slave cycle is forced off and err goes to the owner.
  always_comb begin
    wb_cyc_o   = 1'b0;
    wb_stb_o   = 1'b0;
    wb_we_o    = 1'b0;
    wb_adr_o   = '0;
    wb_dat_o   = '0;
    wb_sel_o   = '0;
    m0_dat_o   = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_dat_o   = '0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_stall_o = 1'b1;

    if (wb_rst_n_i) begin
      case (r_state)
        ST_OWN0: begin
          wb_cyc_o   = m0_cyc_i & ~w_timeout;
          wb_stb_o   = m0_stb_i & ~w_timeout;
          wb_we_o    = m0_we_i;
          wb_adr_o   = m0_adr_i;
          wb_dat_o   = m0_dat_i;
          wb_sel_o   = m0_sel_i;
          m0_dat_o   = wb_dat_i;
          m0_ack_o   = wb_ack_i;
          m0_err_o   = wb_err_i | w_timeout;
          m0_stall_o = wb_stall_i;
        end
        ST_OWN1: begin
          wb_cyc_o   = m1_cyc_i & ~w_timeout;
          wb_stb_o   = m1_stb_i & ~w_timeout;
          wb_we_o    = m1_we_i;
          wb_adr_o   = m1_adr_i;
          wb_dat_o   = m1_dat_i;
          wb_sel_o   = m1_sel_i;
          m1_dat_o   = wb_dat_i;
          m1_ack_o   = wb_ack_i;
          m1_err_o   = wb_err_i | w_timeout;
          m1_stall_o = wb_stall_i;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//   Self-checking bench for wb_arbiter. Two instances share all inputs: dut
//   is round-robin, dutFp is fixed priority. Both use TIMEOUT=8. The bench
//   plays both masters and the slave from scripted cycles. Expected slave
//   addresses and returned read data are queued as stimulus is driven and
//   compared by a monitor when the arbiter accepts a beat or delivers an ack.
//   The watchdog section follows WB_ARBITER_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  logic        clk;
  logic        rstN;

  logic        m0Cyc, m0Stb, m0We;
  logic [31:0] m0Adr, m0DatW;
  logic [3:0]  m0Sel;
  logic        m1Cyc, m1Stb, m1We;
  logic [31:0] m1Adr, m1DatW;
  logic [3:0]  m1Sel;
  logic [31:0] slvDat;
  logic        slvAck, slvErr, slvStall;

  logic [31:0] m0DatR, m1DatR;
  logic        m0Ack, m0Err, m0Stall, m1Ack, m1Err, m1Stall;
  logic        sCyc, sStb, sWe;
  logic [31:0] sAdr, sDat;
  logic [3:0]  sSel;

  logic [31:0] fpM0DatR, fpM1DatR;
  logic        fpM0Ack, fpM0Err, fpM0Stall, fpM1Ack, fpM1Err, fpM1Stall;
  logic        fpCyc, fpStb, fpWe;
  logic [31:0] fpAdr, fpDat;
  logic [3:0]  fpSel;

  int          checks;
  int          errors;
  int          ack0Seen;
  int          ack1Seen;
  logic        sbEnable;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] qAdr[$];

  wb_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rstN),
    .m0_cyc_i(m0Cyc), .m0_stb_i(m0Stb), .m0_we_i(m0We), .m0_adr_i(m0Adr),
    .m0_dat_i(m0DatW), .m0_sel_i(m0Sel), .m0_dat_o(m0DatR), .m0_ack_o(m0Ack),
    .m0_err_o(m0Err), .m0_stall_o(m0Stall),
    .m1_cyc_i(m1Cyc), .m1_stb_i(m1Stb), .m1_we_i(m1We), .m1_adr_i(m1Adr),
    .m1_dat_i(m1DatW), .m1_sel_i(m1Sel), .m1_dat_o(m1DatR), .m1_ack_o(m1Ack),
    .m1_err_o(m1Err), .m1_stall_o(m1Stall),
    .wb_cyc_o(sCyc), .wb_stb_o(sStb), .wb_we_o(sWe), .wb_adr_o(sAdr),
    .wb_dat_o(sDat), .wb_sel_o(sSel), .wb_dat_i(slvDat), .wb_ack_i(slvAck),
    .wb_err_i(slvErr), .wb_stall_i(slvStall)
  );

  wb_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT(8)) dutFp (
    .wb_clk_i(clk), .wb_rst_n_i(rstN),
    .m0_cyc_i(m0Cyc), .m0_stb_i(m0Stb), .m0_we_i(m0We), .m0_adr_i(m0Adr),
    .m0_dat_i(m0DatW), .m0_sel_i(m0Sel), .m0_dat_o(fpM0DatR), .m0_ack_o(fpM0Ack),
    .m0_err_o(fpM0Err), .m0_stall_o(fpM0Stall),
    .m1_cyc_i(m1Cyc), .m1_stb_i(m1Stb), .m1_we_i(m1We), .m1_adr_i(m1Adr),
    .m1_dat_i(m1DatW), .m1_sel_i(m1Sel), .m1_dat_o(fpM1DatR), .m1_ack_o(fpM1Ack),
    .m1_err_o(fpM1Err), .m1_stall_o(fpM1Stall),
    .wb_cyc_o(fpCyc), .wb_stb_o(fpStb), .wb_we_o(fpWe), .wb_adr_o(fpAdr),
    .wb_dat_o(fpDat), .wb_sel_o(fpSel), .wb_dat_i(slvDat), .wb_ack_i(slvAck),
    .wb_err_i(slvErr), .wb_stall_i(slvStall)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives every master and slave input for the coming cycle.
  task automatic applyStimulus(input logic c0, input logic s0, input logic [31:0] a0,
                               input logic c1, input logic s1, input logic [31:0] a1,
                               input logic ack, input logic err, input logic stall,
                               input logic [31:0] dat);
    m0Cyc    = c0;
    m0Stb    = s0;
    m0Adr    = a0;
    m1Cyc    = c1;
    m1Stb    = s1;
    m1Adr    = a1;
    slvAck   = ack;
    slvErr   = err;
    slvStall = stall;
    slvDat   = dat;
  endtask

  task automatic waitNeg();
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    waitNeg();
    nextCycle();
  endtask

  // Scoreboard monitor on the round-robin instance: accepted beats pop the
  // expected address, delivered acks pop the expected read data.
  always @(negedge clk) begin
    if (sbEnable) begin
      if (m0Ack) begin
        ack0Seen++;
        if (q0.size() == 0) checkOutput("ack0Spurious", 32'd1, 32'd0);
        else checkOutput("ack0Data", m0DatR, q0.pop_front());
      end
      if (m1Ack) begin
        ack1Seen++;
        if (q1.size() == 0) checkOutput("ack1Spurious", 32'd1, 32'd0);
        else checkOutput("ack1Data", m1DatR, q1.pop_front());
      end
      if (sCyc && sStb && !slvStall) begin
        if (qAdr.size() == 0) checkOutput("adrSpurious", 32'd1, 32'd0);
        else checkOutput("beatAdr", sAdr, qAdr.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] d;
    checks   = 0;
    errors   = 0;
    ack0Seen = 0;
    ack1Seen = 0;
    sbEnable = 1'b0;
    m0We     = 1'b1;
    m0DatW   = 32'h5A5A_0000;
    m0Sel    = 4'hF;
    m1We     = 1'b0;
    m1DatW   = 32'h0000_A5A5;
    m1Sel    = 4'h3;

    // Reset held for three cycles with both masters requesting.
    rstN = 1'b0;
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      waitNeg();
      checkOutput("rstCyc", {31'd0, sCyc}, 32'd0);
      checkOutput("rstStall", {30'd0, m1Stall, m0Stall}, 32'd3);
      checkOutput("rstFpStall", {30'd0, fpM1Stall, fpM0Stall}, 32'd3);
      nextCycle();
    end
    rstN = 1'b1;
    waitNeg();
    checkOutput("postRstIdleCyc", {31'd0, sCyc}, 32'd0);
    checkOutput("postRstIdleStall", {30'd0, m1Stall, m0Stall}, 32'd3);
    nextCycle();
    waitNeg();
    checkOutput("firstGrantM0", {30'd0, m1Stall, m0Stall}, 32'd2);
    checkOutput("firstGrantCyc", {31'd0, sCyc}, 32'd1);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    waitNeg();
    checkOutput("dropCyc", {31'd0, sCyc}, 32'd0);
    nextCycle();
    idleCycle();

    // Master 1 four-beat read burst, slave acks one cycle after each beat.
    sbEnable = 1'b1;
    ack0Seen = 0;
    ack1Seen = 0;
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 32'h0);
    waitNeg();
    checkOutput("burstWaitStall", {31'd0, m1Stall}, 32'd1);
    nextCycle();
    for (int b = 0; b < 5; b++) begin
      d = 32'hA000_0000 + 32'(b) - 32'd1;
      applyStimulus(0, 0, 32'h0, 1, b < 4, 32'h100 + 32'(4 * b), b > 0, 0, 0, d);
      if (b < 4) qAdr.push_back(32'h100 + 32'(4 * b));
      if (b > 0) q1.push_back(d);
      waitNeg();
      checkOutput("burstM0Ack", {31'd0, m0Ack}, 32'd0);
      checkOutput("burstM1Err", {31'd0, m1Err}, 32'd0);
      if (b == 0) begin
        checkOutput("burstMirror", {27'd0, sWe, sSel}, 32'h3);
        checkOutput("burstWdat", sDat, 32'h0000_A5A5);
      end
      nextCycle();
    end
    idleCycle();
    checkOutput("burstAck1Count", 32'(ack1Seen), 32'd4);
    checkOutput("burstAck0Count", 32'(ack0Seen), 32'd0);
    idleCycle();

    // Round-robin tie: both request, each owner does one beat then drops.
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1, 0, 32'h1000, 1, 0, 32'h2000, 0, 0, 0, 32'h0);
      waitNeg();
      checkOutput("rrIdleCyc", {31'd0, sCyc}, 32'd0);
      nextCycle();
      applyStimulus(1, r % 2 == 0, 32'h1000, 1, r % 2 == 1, 32'h2000, 0, 0, 0, 32'h0);
      qAdr.push_back((r % 2 == 1) ? 32'h2000 : 32'h1000);
      waitNeg();
      checkOutput("rrGrant", {30'd0, m1Stall, m0Stall}, (r % 2 == 1) ? 32'd1 : 32'd2);
      nextCycle();
      d = 32'hB000_0000 + 32'(r);
      applyStimulus(1, 0, 32'h1000, 1, 0, 32'h2000, 1, 0, 0, d);
      if (r % 2 == 1) q1.push_back(d);
      else q0.push_back(d);
      waitNeg();
      nextCycle();
      applyStimulus(r % 2 == 1, 0, 32'h1000, r % 2 == 0, 0, 32'h2000, 0, 0, 0, 32'h0);
      waitNeg();
      checkOutput("rrDropCyc", {31'd0, sCyc}, 32'd0);
      nextCycle();
    end
    idleCycle();
    idleCycle();

    // Fixed priority: master 0 re-raises cyc at once, master 1 never wins.
    sbEnable = 1'b0;
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1, 0, 32'h1000, 1, 0, 32'h2000, 0, 0, 0, 32'h0);
      waitNeg();
      checkOutput("fpIdleM1Stall", {31'd0, fpM1Stall}, 32'd1);
      nextCycle();
      applyStimulus(1, 1, 32'h1000, 1, 0, 32'h2000, 0, 0, 0, 32'h0);
      waitNeg();
      checkOutput("fpGrant", {30'd0, fpM1Stall, fpM0Stall}, 32'd2);
      checkOutput("fpAdr", fpAdr, 32'h1000);
      checkOutput("fpMirror", {25'd0, fpCyc, fpStb, fpWe, fpSel}, 32'h7F);
      checkOutput("fpWdat", fpDat, 32'h5A5A_0000);
      nextCycle();
      d = 32'hF000_0000 + 32'(r);
      applyStimulus(1, 0, 32'h1000, 1, 0, 32'h2000, 1, 0, 0, d);
      waitNeg();
      checkOutput("fpAckRoute", {30'd0, fpM1Ack, fpM0Ack}, 32'd1);
      checkOutput("fpAckData", fpM0DatR, d);
      checkOutput("fpOtherQuiet", fpM1DatR | {30'd0, fpM1Err, fpM0Err}, 32'd0);
      checkOutput("fpOwnM1Stall", {31'd0, fpM1Stall}, 32'd1);
      nextCycle();
      applyStimulus(0, 0, 32'h1000, 1, 0, 32'h2000, 0, 0, 0, 32'h0);
      waitNeg();
      checkOutput("fpDropM1Stall", {31'd0, fpM1Stall}, 32'd1);
      nextCycle();
    end
    idleCycle();
    idleCycle();

    // Slave stall passthrough: address held stable while stalled.
    sbEnable = 1'b1;
    applyStimulus(1, 0, 32'h300, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    waitNeg();
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 32'h300, 0, 0, 32'h0, 0, 0, 1, 32'h0);
      waitNeg();
      checkOutput("stallPass", {31'd0, m0Stall}, 32'd1);
      checkOutput("stallAdr", sAdr, 32'h300);
      nextCycle();
    end
    applyStimulus(1, 1, 32'h300, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    qAdr.push_back(32'h300);
    waitNeg();
    checkOutput("stallRelease", {31'd0, m0Stall}, 32'd0);
    nextCycle();
    applyStimulus(1, 0, 32'h300, 0, 0, 32'h0, 1, 0, 0, 32'hC0DE_0300);
    q0.push_back(32'hC0DE_0300);
    waitNeg();
    nextCycle();
    idleCycle();

    // Reset asserted mid-cycle drops the slave cycle and the in-flight ack.
    applyStimulus(1, 0, 32'h400, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    waitNeg();
    nextCycle();
    applyStimulus(1, 1, 32'h400, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    qAdr.push_back(32'h400);
    waitNeg();
    checkOutput("midRstOwned", {31'd0, sCyc}, 32'd1);
    nextCycle();
    rstN = 1'b0;
    applyStimulus(1, 0, 32'h400, 0, 0, 32'h0, 1, 0, 0, 32'hDEAD_BEEF);
    waitNeg();
    checkOutput("midRstCyc", {31'd0, sCyc}, 32'd0);
    checkOutput("midRstAck", {31'd0, m0Ack}, 32'd0);
    nextCycle();
    rstN = 1'b1;
    applyStimulus(1, 0, 32'h400, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    waitNeg();
    checkOutput("midRstIdle", {30'd0, sCyc, m0Stall}, 32'd1);
    nextCycle();
    idleCycle();
    idleCycle();

    // Watchdog: master 0 owns and the slave never answers.
    applyStimulus(1, 0, 32'h500, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    waitNeg();
    nextCycle();
`ifdef WB_ARBITER_TIMEOUT_EN
    for (int n = 1; n <= 9; n++) begin
      applyStimulus(1, n == 1, 32'h500, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      if (n == 1) qAdr.push_back(32'h500);
      waitNeg();
      if (n < 9) begin
        checkOutput("toErrLow", {31'd0, m0Err}, 32'd0);
        checkOutput("toCycHigh", {31'd0, sCyc}, 32'd1);
      end else begin
        checkOutput("toErrPulse", {31'd0, m0Err}, 32'd1);
        checkOutput("toCycForced", {31'd0, sCyc}, 32'd0);
      end
      nextCycle();
    end
    for (int n = 0; n < 2; n++) begin
      applyStimulus(1, 0, 32'h500, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      waitNeg();
      checkOutput("toBlocked", {29'd0, sCyc, m0Err, m0Stall}, 32'd1);
      nextCycle();
    end
    idleCycle();
    applyStimulus(1, 0, 32'h500, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    waitNeg();
    nextCycle();
    waitNeg();
    checkOutput("toRegrant", {31'd0, sCyc}, 32'd1);
    nextCycle();
`else
    for (int n = 1; n <= 20; n++) begin
      applyStimulus(1, n == 1, 32'h500, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      if (n == 1) qAdr.push_back(32'h500);
      waitNeg();
      checkOutput("noToErr", {31'd0, m0Err}, 32'd0);
      checkOutput("noToHold", {31'd0, sCyc}, 32'd1);
      nextCycle();
    end
`endif
    idleCycle();
    idleCycle();

    checkOutput("sbQ0Empty", 32'(q0.size()), 32'd0);
    checkOutput("sbQ1Empty", 32'(q1.size()), 32'd0);
    checkOutput("sbAdrEmpty", 32'(qAdr.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
